// File: rtl/cla_pipe_if.sv
// Operand/result handshake bundle for cla_pipe: valid/ready on both sides plus NZCV result.
interface cla_pipe_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       op;
    logic             ci;
    logic             sat;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             c;
    logic             v;
    logic             z;
    logic             n;

    modport master (
        output in_valid, a, b, op, ci, sat, out_ready,
        input  in_ready, out_valid, s, c, v, z, n
    );

    modport slave (
        input  in_valid, a, b, op, ci, sat, out_ready,
        output in_ready, out_valid, s, c, v, z, n
    );
endinterface

// File: rtl/cla_pipe.sv
// cla_pipe: pipelined carry-lookahead add/sub/adc/sbc with global-stall valid/ready and NZCV flags.
// Optional signed saturation clamp is enabled by defining CLA_PIPE_SAT_EN.

module cla_pipe_grp #(
    parameter int GROUP = 4
) (
    input  logic [GROUP-1:0] a,
    input  logic [GROUP-1:0] b,
    input  logic             ci,
    output logic [GROUP-1:0] s,
    output logic             co
);
    logic [GROUP-1:0] g, p;
    logic [GROUP:0]   cy;
    logic             pp;

    assign g = a & b;
    assign p = a ^ b;

    // Every carry is a flat sum of generate terms gated by the propagate run above them.
    always_comb begin
        cy    = '0;
        pp    = 1'b0;
        cy[0] = ci;
        for (int i = 0; i < GROUP; i++) begin
            cy[i+1] = g[i];
            pp      = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                cy[i+1] = cy[i+1] | (pp & g[j]);
                pp      = pp & p[j];
            end
            cy[i+1] = cy[i+1] | (pp & ci);
        end
    end

    assign s  = p ^ cy[GROUP-1:0];
    assign co = cy[GROUP];
endmodule

module cla_pipe #(
    parameter int WIDTH  = 32,
    parameter int GROUP  = 4,
    parameter int STAGES = 2
) (
    input logic       clk,
    input logic       reset_n,
    cla_pipe_if.slave bus
);
    localparam int G   = WIDTH / GROUP;
    localparam int GPS = G / STAGES;
    localparam int SW  = GPS * GROUP;

    logic              adv, xfer;
    logic [STAGES:0]   vld_pipe;
    logic [WIDTH-1:0]  b_prep;
    logic              cin_prep, sat_cap;
    logic [WIDTH-1:0]  a_q, b_q;
    logic              cin_q, sat_q;
    logic [WIDTH-1:0]  s_raw, s_fin;
    logic              c_fin, cmsb, v_raw, sat_fin;
    logic [WIDTH-1:0]  s_q;
    logic              c_q, v_q, z_q, n_q;

    assign adv          = !vld_pipe[STAGES] || bus.out_ready;
    assign xfer         = bus.in_valid && adv;
    assign bus.in_ready = adv;

    assign b_prep   = bus.op[0] ? ~bus.b : bus.b;
    assign cin_prep = bus.op[1] ? bus.ci : bus.op[0];

`ifdef CLA_PIPE_SAT_EN
    assign sat_cap = bus.sat;
`else
    logic unused_sat;
    assign sat_cap    = 1'b0;
    assign unused_sat = bus.sat ^ sat_fin;
`endif

    // Operand capture; bubbles still shift so vld_pipe tracks occupancy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_pipe <= '0;
            a_q      <= '0;
            b_q      <= '0;
            cin_q    <= 1'b0;
            sat_q    <= 1'b0;
        end else if (adv) begin
            vld_pipe <= {vld_pipe[STAGES-1:0], xfer};
            a_q      <= bus.a;
            b_q      <= b_prep;
            cin_q    <= cin_prep;
            sat_q    <= sat_cap;
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : stg
        localparam int LO  = k * SW;
        localparam int REM = WIDTH - LO;

        logic [REM-1:0]   a_in, b_in;
        logic             c_in, sat_in;
        logic [SW-1:0]    slice;
        logic [LO+SW-1:0] acc;
        logic [GPS:0]     gc;

        if (k == 0) begin : src
            assign a_in   = a_q;
            assign b_in   = b_q;
            assign c_in   = cin_q;
            assign sat_in = sat_q;
            assign acc    = slice;
        end else begin : src
            assign a_in   = stg[k-1].nxt.a_r;
            assign b_in   = stg[k-1].nxt.b_r;
            assign c_in   = stg[k-1].nxt.c_r;
            assign sat_in = stg[k-1].nxt.sat_r;
            assign acc    = {slice, stg[k-1].nxt.sum_r};
        end

        assign gc[0] = c_in;
        for (genvar j = 0; j < GPS; j++) begin : grp
            cla_pipe_grp #(.GROUP(GROUP)) u_grp (
                .a  (a_in[j*GROUP +: GROUP]),
                .b  (b_in[j*GROUP +: GROUP]),
                .ci (gc[j]),
                .s  (slice[j*GROUP +: GROUP]),
                .co (gc[j+1])
            );
        end

        if (k < STAGES - 1) begin : nxt
            // Low sum bits skew forward; untouched operand bits ride along for later stages.
            logic [REM-SW-1:0] a_r, b_r;
            logic [LO+SW-1:0]  sum_r;
            logic              c_r, sat_r;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    a_r   <= '0;
                    b_r   <= '0;
                    sum_r <= '0;
                    c_r   <= 1'b0;
                    sat_r <= 1'b0;
                end else if (adv) begin
                    a_r   <= a_in[REM-1:SW];
                    b_r   <= b_in[REM-1:SW];
                    sum_r <= acc;
                    c_r   <= gc[GPS];
                    sat_r <= sat_in;
                end
            end
        end else begin : fin
            assign s_raw   = acc;
            assign c_fin   = gc[GPS];
            assign cmsb    = a_in[SW-1] ^ b_in[SW-1] ^ acc[WIDTH-1];
            assign sat_fin = sat_in;
        end
    end

    assign v_raw = cmsb ^ c_fin;

    always_comb begin
        s_fin = s_raw;
`ifdef CLA_PIPE_SAT_EN
        // Carry into the MSB set means the true result overshot positive.
        if (sat_fin && v_raw)
            s_fin = cmsb ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s_q <= '0;
            c_q <= 1'b0;
            v_q <= 1'b0;
            z_q <= 1'b0;
            n_q <= 1'b0;
        end else if (adv && vld_pipe[STAGES-1]) begin
            s_q <= s_fin;
            c_q <= c_fin;
            v_q <= v_raw;
            z_q <= (s_fin == '0);
            n_q <= s_fin[WIDTH-1];
        end
    end

    assign bus.out_valid = vld_pipe[STAGES];
    assign bus.s         = s_q;
    assign bus.c         = c_q;
    assign bus.v         = v_q;
    assign bus.z         = z_q;
    assign bus.n         = n_q;
endmodule

// File: tb/tb_cla_pipe.sv
// Bench for cla_pipe (WIDTH=32, GROUP=4, STAGES=2): directed vectors, stall/stream, reset flush,
// with a queue scoreboard fed on every input transfer and drained on every output handshake.
module tb_cla_pipe;
    localparam int W = 32;

    typedef struct packed {
        logic [W-1:0] s;
        logic         c, v, z, n;
    } res_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   nacc = 0;
    int   nres = 0;
    res_t sb[$];
    logic held = 1'b0;
    res_t held_v;

    cla_pipe_if #(.WIDTH(W)) bus ();

    cla_pipe #(.WIDTH(W), .GROUP(4), .STAGES(2)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [1:0] op, input logic ci, input logic sat);
        res_t         r;
        logic [W-1:0] bp;
        logic         cin;
        logic [W:0]   full;
        bp   = op[0] ? ~b : b;
        cin  = op[1] ? ci : op[0];
        full = {1'b0, a} + {1'b0, bp} + {{W{1'b0}}, cin};
        r.s  = full[W-1:0];
        r.c  = full[W];
        r.v  = (a[W-1] == bp[W-1]) && (r.s[W-1] != a[W-1]);
`ifdef CLA_PIPE_SAT_EN
        if (sat && r.v) r.s = a[W-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`else
        r.z  = sat;
`endif
        r.z  = (r.s == '0);
        r.n  = r.s[W-1];
        return r;
    endfunction

    // Monitor: push on input transfer, pop/compare on output handshake, check holds under stall.
    always @(negedge clk) begin
        if (!reset_n) begin
            held = 1'b0;
        end else begin
            res_t got, exp;
            got = '{bus.s, bus.c, bus.v, bus.z, bus.n};
            check("in_ready_eq_advance", bus.in_ready, !bus.out_valid || bus.out_ready);
            if (held) begin
                check("held_valid", bus.out_valid, 1'b1);
                check("held_result", got, held_v);
            end
            held   = bus.out_valid && !bus.out_ready;
            held_v = got;
            if (bus.out_valid && bus.out_ready) begin
                check("sb_nonempty", sb.size() != 0, 1'b1);
                if (sb.size() != 0) begin
                    exp = sb.pop_front();
                    check("sb_s", got.s, exp.s);
                    check("sb_cvzn", {got.c, got.v, got.z, got.n}, {exp.c, exp.v, exp.z, exp.n});
                    nres++;
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                sb.push_back(model(bus.a, bus.b, bus.op, bus.ci, bus.sat));
                nacc++;
            end
        end
    end

    task automatic drive_rand();
        bus.a   = ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFF : $urandom;
        bus.b   = ($urandom_range(0, 5) == 0) ? 32'h0000_0001 : $urandom;
        bus.op  = 2'($urandom_range(0, 3));
        bus.ci  = 1'($urandom_range(0, 1));
        bus.sat = 1'($urandom_range(0, 1));
    endtask

    // Called just after a rising edge with an idle pipe and out_ready=1.
    task automatic do_op(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic ci, input logic sat,
                         input logic [W-1:0] es, input logic [3:0] ecvzn);
        bus.op = op; bus.a = a; bus.b = b; bus.ci = ci; bus.sat = sat;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check({tag, "_lat0"}, bus.out_valid, 1'b0);
        @(negedge clk);
        check({tag, "_lat1"}, bus.out_valid, 1'b0);
        @(negedge clk);
        check({tag, "_lat2"}, bus.out_valid, 1'b1);
        check({tag, "_s"}, bus.s, es);
        check({tag, "_cvzn"}, {bus.c, bus.v, bus.z, bus.n}, ecvzn);
        @(posedge clk); #1;
    endtask

    initial begin
        int base_acc, base_res, sent, prev_sent, hold;
        logic dropped;
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        bus.a = '0; bus.b = '0; bus.op = 2'b00; bus.ci = 1'b0; bus.sat = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_s", bus.s, 32'h0);
        check("rst_cvzn", {bus.c, bus.v, bus.z, bus.n}, 4'b0000);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", bus.in_ready, 1'b1);
        @(posedge clk); #1;

        do_op("add_wrap", 2'b00, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 4'b1010);
        do_op("sub_ovf",  2'b01, 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b0, 32'h7FFF_FFFF, 4'b1100);
`ifdef CLA_PIPE_SAT_EN
        do_op("sub_sat",  2'b01, 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h8000_0000, 4'b1101);
        do_op("add_sat",  2'b00, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 4'b0100);
`else
        do_op("sub_sat",  2'b01, 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 4'b1100);
        do_op("add_sat",  2'b00, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 32'h8000_0000, 4'b0101);
`endif
        do_op("sbc",      2'b11, 32'h0000_0005, 32'h0000_0003, 1'b0, 1'b0, 32'h0000_0001, 4'b1000);
        do_op("adc",      2'b10, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 4'b1010);

        // Four back-to-back ops; out_ready drops for 3 cycles when the first result shows.
        base_acc = nacc; base_res = nres; prev_sent = 0; hold = 0; dropped = 1'b0;
        drive_rand();
        bus.in_valid = 1'b1;
        for (int cyc = 0; cyc < 40 && (nres - base_res) < 4; cyc++) begin
            @(posedge clk); #1;
            sent = nacc - base_acc;
            if (sent >= 4) bus.in_valid = 1'b0;
            else if (sent != prev_sent) drive_rand();
            prev_sent = sent;
            if (!dropped && bus.out_valid) begin
                bus.out_ready = 1'b0; dropped = 1'b1; hold = 3;
            end else if (hold > 0) begin
                hold--;
                if (hold == 0) bus.out_ready = 1'b1;
            end
        end
        check("stream_results", nres - base_res, 4);
        check("stream_sb_empty", sb.size(), 0);

        // Random traffic with bubbles and back-pressure.
        for (int cyc = 0; cyc < 80; cyc++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            if (!held || !bus.in_valid) drive_rand();
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        for (int cyc = 0; cyc < 20 && sb.size() != 0; cyc++) @(posedge clk);
        #1;
        check("rand_drain", sb.size(), 0);
        @(posedge clk); #1;

        // Two ops in flight, reset while the first is presented.
        drive_rand(); bus.in_valid = 1'b1;
        @(posedge clk); #1;
        drive_rand();
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        check("pre_rst_valid", bus.out_valid, 1'b1);
        reset_n = 1'b0;
        #1;
        check("async_rst_valid", bus.out_valid, 1'b0);
        check("async_rst_s", bus.s, 32'h0);
        sb.delete();
        @(posedge clk); #1;
        reset_n = 1'b1;
        for (int cyc = 0; cyc < 4; cyc++) begin
            @(negedge clk);
            check("flushed_no_valid", bus.out_valid, 1'b0);
        end
        @(posedge clk); #1;
        do_op("post_rst_add", 2'b00, 32'h0000_1234, 32'h0000_4321, 1'b0, 1'b0, 32'h0000_5555, 4'b0000);
        check("final_sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
